// File: rtl/pose_sequencer_pkg.sv
// pose_pkg: shared jog encodings, sequencer state type and the fixed pose table.
// Poses are stored joint1-first: element [0] of a pose_t is joint 1.
package pose_pkg;

  localparam logic [1:0] BTN_HOLD = 2'b00;
  localparam logic [1:0] BTN_UP   = 2'b01;
  localparam logic [1:0] BTN_DOWN = 2'b10;

  localparam int unsigned N_JOINTS = 5;
  localparam int unsigned N_TABLE  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MOVE  = 3'd2,
    DWELL = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef logic [N_JOINTS-1:0][7:0] pose_t;

  // Each literal is written {j5, j4, j3, j2, j1}; entries at or beyond N_POSES are ignored.
  localparam pose_t POSE_TABLE [N_TABLE] = '{
    {8'd100, 8'd100, 8'd100, 8'd100, 8'd100},
    {8'd32,  8'd64,  8'd128, 8'd255, 8'd0  },
    {8'd240, 8'd10,  8'd150, 8'd50,  8'd200},
    {8'd5,   8'd220, 8'd90,  8'd180, 8'd30 },
    {8'd128, 8'd128, 8'd128, 8'd128, 8'd128},
    {8'd20,  8'd240, 8'd180, 8'd120, 8'd60 },
    {8'd175, 8'd75,  8'd125, 8'd5,   8'd250},
    {8'd50,  8'd40,  8'd30,  8'd20,  8'd10 },
    {8'd90,  8'd90,  8'd90,  8'd90,  8'd90 },
    {8'd64,  8'd192, 8'd64,  8'd192, 8'd64 },
    {8'd200, 8'd100, 8'd200, 8'd100, 8'd200},
    {8'd0,   8'd0,   8'd0,   8'd0,   8'd0  },
    {8'd255, 8'd255, 8'd255, 8'd255, 8'd255},
    {8'd16,  8'd48,  8'd80,  8'd112, 8'd144},
    {8'd144, 8'd112, 8'd80,  8'd48,  8'd16 },
    {8'd128, 8'd64,  8'd32,  8'd16,  8'd8  }
  };

endpackage

// File: rtl/pose_sequencer_joint_cmp.sv
// joint_cmp: compares one joint position to its target and proposes the jog
// direction. The difference is formed in 9 bits so 0 vs 255 cannot wrap.
module joint_cmp
  import pose_pkg::*;
#(
  parameter int unsigned TOL = 2
) (
  input  logic [7:0] pos,
  input  logic [7:0] tgt,
  output logic [1:0] btn_next,
  output logic       at_tgt
);

  logic signed [8:0] diff_s;
  logic        [8:0] mag_s;

  // Signed distance, its magnitude, and the resulting jog direction.
  always_comb begin
    diff_s = $signed({1'b0, pos}) - $signed({1'b0, tgt});
    if (diff_s[8]) begin
      mag_s = $unsigned(-diff_s);
    end else begin
      mag_s = $unsigned(diff_s);
    end
    at_tgt = (mag_s <= 9'(TOL));
    if (at_tgt) begin
      btn_next = BTN_HOLD;
    end else if (diff_s[8]) begin
      btn_next = BTN_UP;
    end else begin
      btn_next = BTN_DOWN;
    end
  end

endmodule

// File: rtl/pose_sequencer.sv
// pose_sequencer: plays back the pose table by jogging five servo joints to
// each target, dwelling once all are within tolerance, then advancing.
// Build option POSE_LOOP_EN: when defined the sequence wraps to pose 0
// forever and DONE is never entered (done stays 0).
module pose_sequencer
  import pose_pkg::*;
#(
  parameter int unsigned N_POSES      = 8,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned TOL          = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw,
  input  logic [7:0] pos1,
  input  logic [7:0] pos2,
  input  logic [7:0] pos3,
  input  logic [7:0] pos4,
  input  logic [7:0] pos5,
  output logic [1:0] btn1,
  output logic [1:0] btn2,
  output logic [1:0] btn3,
  output logic [1:0] btn4,
  output logic [1:0] btn5,
  output logic [3:0] step_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0]  LAST_STEP = 4'(N_POSES - 1);
  localparam logic [31:0] LAST_CNT  = 32'(DWELL_CYCLES - 1);

  logic [7:0]                 pos_s [N_JOINTS];
  logic [N_JOINTS-1:0][1:0]   btn_next_s;
  logic [N_JOINTS-1:0]        at_tgt_s;
  logic                       all_at_s;

  state_e                     state_q, state_d;
  pose_t                      tgt_q, tgt_d;
  logic [N_JOINTS-1:0][1:0]   btn_q, btn_d;
  logic [3:0]                 step_q, step_d;
  logic [31:0]                cnt_q, cnt_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  assign pos_s[0] = pos1;
  assign pos_s[1] = pos2;
  assign pos_s[2] = pos3;
  assign pos_s[3] = pos4;
  assign pos_s[4] = pos5;

  for (genvar j = 0; j < N_JOINTS; j++) begin : g_joint
    joint_cmp #(.TOL(TOL)) u_cmp (
      .pos      (pos_s[j]),
      .tgt      (tgt_q[j]),
      .btn_next (btn_next_s[j]),
      .at_tgt   (at_tgt_s[j])
    );
  end

  assign all_at_s = &at_tgt_s;

  // Next-state, target latch, dwell counter and jog command selection.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    btn_d   = {N_JOINTS{BTN_HOLD}};
    if (!sw) begin
      // Abort: no partial-pose resume, always restart from pose 0.
      state_d = IDLE;
      step_d  = 4'd0;
      cnt_d   = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = LOAD;
        end
        LOAD: begin
          tgt_d   = POSE_TABLE[step_q];
          state_d = MOVE;
        end
        MOVE: begin
          btn_d = btn_next_s;
          if (all_at_s) begin
            state_d = DWELL;
            cnt_d   = 32'd0;
          end else begin
            state_d = MOVE;
          end
        end
        DWELL: begin
          if (!all_at_s) begin
            state_d = MOVE;
            cnt_d   = 32'd0;
          end else if (cnt_q == LAST_CNT) begin
            cnt_d = 32'd0;
            if (step_q == LAST_STEP) begin
`ifdef POSE_LOOP_EN
              step_d  = 4'd0;
              state_d = LOAD;
`else
              state_d = DONE;
`endif
            end else begin
              step_d  = step_q + 4'd1;
              state_d = LOAD;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          step_d  = 4'd0;
          cnt_d   = 32'd0;
        end
      endcase
    end
    busy_d = (state_d == LOAD) || (state_d == MOVE) || (state_d == DWELL);
`ifdef POSE_LOOP_EN
    done_d = 1'b0;
`else
    done_d = (state_d == DONE);
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      btn_q   <= {N_JOINTS{BTN_HOLD}};
      step_q  <= 4'd0;
      cnt_q   <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      btn_q   <= btn_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign btn1     = btn_q[0];
  assign btn2     = btn_q[1];
  assign btn3     = btn_q[2];
  assign btn4     = btn_q[3];
  assign btn5     = btn_q[4];
  assign step_idx = step_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pose_sequencer.sv
// tb_pose_sequencer: directed playback of a 4-pose, 10-cycle-dwell sequencer.
// Expected output words are queued as each step is driven and compared once
// the following clock edge has produced the DUT response.
module tb_pose_sequencer;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 10;
  localparam int unsigned TL = 2;

  logic       clk = 1'b0;
  logic       rst, sw;
  logic [7:0] pos1, pos2, pos3, pos4, pos5;
  logic [1:0] btn1, btn2, btn3, btn4, btn5;
  logic [3:0] step_idx;
  logic       busy, done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t sb_q[$];

  logic [15:0] obs_s;
  assign obs_s = {btn1, btn2, btn3, btn4, btn5, step_idx, busy, done};

  always #5 clk = ~clk;

  pose_sequencer #(.N_POSES(NP), .DWELL_CYCLES(DW), .TOL(TL)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .btn1(btn1), .btn2(btn2), .btn3(btn3), .btn4(btn4), .btn5(btn5),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  // The illegal jog code 11 must never appear on any joint.
  always @(negedge clk) begin
    n_cmp++;
    assert (!(btn1 === 2'b11 || btn2 === 2'b11 || btn3 === 2'b11 ||
              btn4 === 2'b11 || btn5 === 2'b11))
    else begin
      n_err++;
      $error("FAIL btn_11 observed=%b_%b_%b_%b_%b expected=no 11", btn1, btn2, btn3, btn4, btn5);
    end
  end

  function automatic logic [15:0] ex(input logic [9:0] b, input logic [3:0] s,
                                     input logic bz, input logic dn);
    return {b, s, bz, dn};
  endfunction

  task automatic setp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic [7:0] e);
    pos1 = a; pos2 = b; pos3 = c; pos4 = d; pos5 = e;
  endtask

  task automatic chk(input string tag, input logic [15:0] v);
    exp_t e;
    sb_q.push_back('{tag, v});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    assert (obs_s === e.val)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs_s, e.val);
    end
  endtask

  task automatic hold_dwell(input int p);
    for (int i = 0; i < 9; i++) chk($sformatf("dwell%0d_%0d", p, i), ex(10'd0, 4'(p), 1'b1, 1'b0));
  endtask

  // Entered with the DUT in LOAD for pose p; pos already matches the target.
  task automatic pose_sat(input int p, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
    setp(a, b, c, d, e);
    chk($sformatf("p%0d_move", p), ex(10'd0, 4'(p), 1'b1, 1'b0));
    chk($sformatf("p%0d_dwell_in", p), ex(10'd0, 4'(p), 1'b1, 1'b0));
    hold_dwell(p);
  endtask

  initial begin
    rst = 1'b1;
    sw  = 1'b1;
    setp(8'd90, 8'd90, 8'd90, 8'd90, 8'd90);
    chk("rst0", ex(10'd0, 4'd0, 1'b0, 1'b0));
    chk("rst1", ex(10'd0, 4'd0, 1'b0, 1'b0));
    rst = 1'b0;
    chk("idle_to_load", ex(10'd0, 4'd0, 1'b1, 1'b0));
    chk("load_hold", ex(10'd0, 4'd0, 1'b1, 1'b0));
    chk("move_all_up", ex({5{2'b01}}, 4'd0, 1'b1, 1'b0));
    pos1 = 8'd98;
    chk("j1_in_tol", ex({2'b00, 2'b01, 2'b01, 2'b01, 2'b01}, 4'd0, 1'b1, 1'b0));
    setp(8'd100, 8'd101, 8'd99, 8'd100, 8'd102);
    chk("all_at_dwell", ex(10'd0, 4'd0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) chk("dwell_pre", ex(10'd0, 4'd0, 1'b1, 1'b0));
    pos3 = 8'd105;
    chk("drift_to_move", ex(10'd0, 4'd0, 1'b1, 1'b0));
    chk("drift_btn3_down", ex({2'b00, 2'b00, 2'b10, 2'b00, 2'b00}, 4'd0, 1'b1, 1'b0));
    pos3 = 8'd100;
    chk("redwell", ex(10'd0, 4'd0, 1'b1, 1'b0));
    hold_dwell(0);
    chk("adv_step1", ex(10'd0, 4'd1, 1'b1, 1'b0));
    // Pose 1 targets j1=0, j2=255: drive the opposite extremes.
    setp(8'd255, 8'd0, 8'd128, 8'd64, 8'd32);
    chk("load1_move", ex(10'd0, 4'd1, 1'b1, 1'b0));
    chk("extremes", ex({2'b10, 2'b01, 2'b00, 2'b00, 2'b00}, 4'd1, 1'b1, 1'b0));
    chk("extremes_hold", ex({2'b10, 2'b01, 2'b00, 2'b00, 2'b00}, 4'd1, 1'b1, 1'b0));
    setp(8'd0, 8'd255, 8'd128, 8'd64, 8'd32);
    chk("p1_dwell_in", ex(10'd0, 4'd1, 1'b1, 1'b0));
    hold_dwell(1);
    chk("adv_step2", ex(10'd0, 4'd2, 1'b1, 1'b0));
    pose_sat(2, 8'd200, 8'd50, 8'd150, 8'd10, 8'd240);
    chk("adv_step3", ex(10'd0, 4'd3, 1'b1, 1'b0));
    chk("load3_move", ex(10'd0, 4'd3, 1'b1, 1'b0));
    chk("p3_dirs", ex({2'b10, 2'b01, 2'b10, 2'b01, 2'b10}, 4'd3, 1'b1, 1'b0));
    sw = 1'b0;
    chk("abort_idle", ex(10'd0, 4'd0, 1'b0, 1'b0));
    chk("abort_stay", ex(10'd0, 4'd0, 1'b0, 1'b0));
    sw = 1'b1;
    setp(8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
    chk("restart_load", ex(10'd0, 4'd0, 1'b1, 1'b0));
    pose_sat(0, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
    chk("r_adv1", ex(10'd0, 4'd1, 1'b1, 1'b0));
    pose_sat(1, 8'd0, 8'd255, 8'd128, 8'd64, 8'd32);
    chk("r_adv2", ex(10'd0, 4'd2, 1'b1, 1'b0));
    pose_sat(2, 8'd200, 8'd50, 8'd150, 8'd10, 8'd240);
    chk("r_adv3", ex(10'd0, 4'd3, 1'b1, 1'b0));
    pose_sat(3, 8'd30, 8'd180, 8'd90, 8'd220, 8'd5);
`ifdef POSE_LOOP_EN
    chk("wrap_step0", ex(10'd0, 4'd0, 1'b1, 1'b0));
    chk("wrap_move", ex(10'd0, 4'd0, 1'b1, 1'b0));
    chk("wrap_dirs", ex({2'b01, 2'b10, 2'b01, 2'b10, 2'b01}, 4'd0, 1'b1, 1'b0));
`else
    chk("done", ex(10'd0, 4'd3, 1'b0, 1'b1));
    setp(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    chk("done_hold", ex(10'd0, 4'd3, 1'b0, 1'b1));
    chk("done_hold2", ex(10'd0, 4'd3, 1'b0, 1'b1));
    sw = 1'b0;
    chk("done_to_idle", ex(10'd0, 4'd0, 1'b0, 1'b0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
